// File: rtl/int_controller.sv
// Parametrised interrupt controller: synchronised sources, edge/level capture, two priority-group
// CPU lines, vector register with ACK retire. Register reads have one-cycle latency.
module int_controller #(
  parameter int NUM_INTS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  CS,
  input  logic [2:0]            ADDR,
  input  logic                  WR,
  input  logic                  RD,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic [DATA_WIDTH-1:0] DOUT,
  input  logic [NUM_INTS-1:0]   IRQ_IN,
  input  logic                  ACK,
  output logic                  INT0,
  output logic                  INT1
);

  localparam logic [2:0] A_MASK  = 3'd0;
  localparam logic [2:0] A_PEND  = 3'd1;
  localparam logic [2:0] A_MODE  = 3'd2;
  localparam logic [2:0] A_POL   = 3'd3;
  localparam logic [2:0] A_PRIO  = 3'd4;
  localparam logic [2:0] A_VEC   = 3'd5;
  localparam logic [2:0] A_SWSET = 3'd6;
  localparam logic [2:0] A_RAW   = 3'd7;

  logic [NUM_INTS-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_INTS-1:0]   mask_q, pend_q, mode_q, pol_q, prio_q, prev_q;
  logic [NUM_INTS-1:0]   pend_d, act, elig, hi, lo, set_v, clr_v, ack_clr, din_n;
  logic [DATA_WIDTH-1:0] dout_q, rd_dat;
  logic                  int0_q, int1_q;
  logic                  wr_en, rd_en, vec_vld;
  logic [3:0]            vec_idx;
  logic [15:0]           vec16;
  logic                  unused_din;

  assign wr_en      = CS & WR;
  assign rd_en      = CS & RD;
  assign din_n      = DIN[NUM_INTS-1:0];
  assign unused_din = ^(DIN >> NUM_INTS);

  assign act  = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign elig = pend_q & mask_q;
  assign hi   = elig & prio_q;
  assign lo   = elig & ~prio_q;

  // High group wins outright; descending scan leaves the lowest index selected.
  always_comb begin
    vec_vld = |elig;
    vec_idx = '0;
    for (int i = NUM_INTS-1; i >= 0; i--)
      if (lo[i]) vec_idx = 4'(i);
    if (|hi)
      for (int i = NUM_INTS-1; i >= 0; i--)
        if (hi[i]) vec_idx = 4'(i);
  end

  assign vec16 = {vec_vld, 11'b0, vec_idx};

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_INTS; i++)
      if (ACK && vec_vld && vec_idx == 4'(i) && mode_q[i]) ack_clr[i] = 1'b1;
  end

  // Edge channels: set beats clear. Level channels simply track act.
  always_comb begin
    set_v  = (act & ~prev_q) | ((wr_en && ADDR == A_SWSET) ? din_n : '0);
    clr_v  = ((wr_en && ADDR == A_PEND) ? din_n : '0) | ack_clr;
    pend_d = (mode_q & ((pend_q & ~clr_v) | set_v)) | (~mode_q & act);
  end

  always_comb begin
    rd_dat = '0;
    case (ADDR)
      A_MASK:  rd_dat = DATA_WIDTH'(mask_q);
      A_PEND:  rd_dat = DATA_WIDTH'(pend_q);
      A_MODE:  rd_dat = DATA_WIDTH'(mode_q);
      A_POL:   rd_dat = DATA_WIDTH'(pol_q);
      A_PRIO:  rd_dat = DATA_WIDTH'(prio_q);
      A_VEC:   rd_dat = DATA_WIDTH'(vec16);
      A_RAW:   rd_dat = DATA_WIDTH'(act);
      default: rd_dat = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= IRQ_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      prio_q <= '0;
    end else if (wr_en) begin
      case (ADDR)
        A_MASK:  mask_q <= din_n;
        A_MODE:  mode_q <= din_n;
        A_POL:   pol_q  <= din_n;
        A_PRIO:  prio_q <= din_n;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_q <= '0;
      prev_q <= '0;
      dout_q <= '0;
      int0_q <= 1'b0;
      int1_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      prev_q <= act;
      int1_q <= |(pend_q & mask_q & prio_q);
      int0_q <= |(pend_q & mask_q & ~prio_q);
      if (rd_en) dout_q <= rd_dat;
    end
  end

  assign DOUT = dout_q;
  assign INT0 = int0_q;
  assign INT1 = int1_q;

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Parametrised interrupt controller. Replaces the fixed seven-input interrupt mask logic inside the MCU resources block.
- Accepts NUM_INTS asynchronous external interrupt sources and synchronises each one.
- Per-channel configuration: edge or level mode, polarity, mask, and priority group.
- Drives the two CPU interrupt lines INT0 (low group) and INT1 (high group). Provides a vector register and an ACK handshake so the CPU can identify and retire sources.

Parameters:
- NUM_INTS, 8, number of interrupt sources (1..16).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- DATA_WIDTH, 16, register and bus width. Must be >= NUM_INTS.

Ports:
- CLK  input  1  system clock.
- RESETN  input  1  asynchronous active-low reset.
- CS  input  1  register block select.
- ADDR  input  3  register address.
- WR  input  1  write strobe, sampled on CLK when CS=1.
- RD  input  1  read strobe, sampled on CLK when CS=1.
- DIN  input  DATA_WIDTH  write data from CPU.
- DOUT  output  DATA_WIDTH  registered read data.
- IRQ_IN  input  NUM_INTS  raw external interrupt sources, asynchronous.
- ACK  input  1  one-cycle pulse: CPU retires the currently vectored source.
- INT0  output  1  low-priority-group interrupt request to CPU.
- INT1  output  1  high-priority-group interrupt request to CPU.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - All registers, sync chains, edge history, DOUT, INT0 and INT1 go to 0.
  - Release is synchronous to the CLK edge.
- Register map (ADDR):
  - 0 MASK RW (1 = enabled).
  - 1 PENDING: read; write-1-to-clear.
  - 2 MODE RW (1 = edge, 0 = level).
  - 3 POLARITY RW (1 = active-low).
  - 4 PRIORITY RW (1 = high group → INT1).
  - 5 VECTOR RO.
  - 6 SWSET WO: write-1 sets PENDING for edge channels.
  - 7 RAW RO: synchronised active levels.
- Bits at or above NUM_INTS read 0; writes to them are ignored.
- Reads: DOUT updates on the CLK edge where CS&RD=1 (one-cycle latency) and holds its value otherwise. Reading SWSET returns 0.
- Per channel i:
  - act[i] = sync[i] XOR POLARITY[i].
  - prev[i] registers act[i] every cycle.
- Edge mode: PENDING[i] sets on the cycle act[i]=1 and prev[i]=0. It stays set until cleared by W1C or ACK.
- Level mode: PENDING[i] = act[i], registered each cycle. W1C and ACK have no lasting effect.
- Simultaneous set and clear (edge, SWSET, W1C, ACK in the same cycle): set wins.
- MASK does not gate PENDING capture. Pending bits of masked channels still latch.
- Reconfiguration: a write to POLARITY or MODE that makes act rise 0→1 on an edge channel sets PENDING. Software clears PENDING after reconfiguring.
- Outputs, registered:
  - INT1 <= |(PENDING & MASK & PRIORITY).
  - INT0 <= |(PENDING & MASK & ~PRIORITY).
- Latency: IRQ_IN edge to INTx assertion is SYNC_STAGES+2 CLK rising edges; 4 for the default.
- VECTOR, combinational from PENDING & MASK:
  - bit 15 = valid.
  - bits [3:0] = selected index.
  - Selection: any high-group source beats any low-group source; within a group, the lowest index wins.
  - With no eligible source, VECTOR = 0x0000.
- ACK:
  - If VECTOR is valid and the selected channel is in edge mode, ACK clears that PENDING bit on this clock.
  - Otherwise ACK has no effect.
  - ACK and W1C in the same cycle: the union of both clears applies.
- Reset asserted mid-operation clears all pending state immediately; INTx deassert without waiting for a clock.

Test Plan:
1. Reset, MASK=0x00FF, MODE=0x00FF. Rising pulse on IRQ_IN[3] → INT0=1 exactly 4 clocks after the edge; PENDING=0x0008; VECTOR=0x8003; ACK pulse → PENDING=0x0000, INT0=0 on the next clock.
2. PRIORITY=0x0020; IRQ_IN[1] and IRQ_IN[5] edges in the same cycle → INT0=1 and INT1=1; VECTOR=0x8005; ACK → VECTOR=0x8001; ACK → VECTOR=0x0000.
3. Level mode on ch2 (MODE bit 2=0), POLARITY bit 2=1:
   - IRQ_IN[2]=0 → INT0=1, RAW bit 2=1.
   - Write PENDING=0x0004 → INT0 stays 1.
   - IRQ_IN[2]=1 → INT0=0 after 4 clocks.
4. MASK=0x0000; edge on ch0 → PENDING=0x0001, INT0=0, VECTOR=0x0000. Write MASK=0x0001 → INT0=1 one clock later.
5. Edge arrives on ch4 in the same cycle as a W1C write of 0x0010 → PENDING bit 4 remains 1. Writing SWSET=0x0010 to a level channel → PENDING unaffected.
6. Pending ch6 with INT0=1; assert RESETN=0 between clock edges → INT0=0 and DOUT=0 immediately. After release, PENDING reads 0x0000.
